// File: rtl/aes_round_sequencer.sv
// Control sequencer that walks the 4x4 AES PE array through one AES-128 block.
// Optional macro SEQ_PERF_CNT_EN adds the cycle_cnt performance counter output.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int SHIFT_CYC  = 3,
    parameter int SUB_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       enc_dec_in,
    input  logic       key_vld,
    input  logic       out_ready,
    output logic       pe_en,
    output logic [1:0] op_sel,
    output logic       load_psum,
    output logic       shift_in_en,
    output logic       enc_dec,
    output logic       key_req,
    output logic [3:0] key_round,
    output logic       busy,
`ifdef SEQ_PERF_CNT_EN
    output logic [7:0] cycle_cnt,
`endif
    output logic       out_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SUB, S_SHIFT, S_MIX, S_KWAIT, S_ADDK, S_OUT
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_CYC - 1);
    localparam logic [7:0] SUB_LAST   = 8'(SUB_LAT - 1);

    state_t     r_state;
    logic [3:0] r_round;
    logic [7:0] r_phase;
    logic       r_dir;

    logic       r_peEn, r_loadPsum, r_shiftInEn, r_encDec, r_keyReq, r_busy, r_outValid;
    logic [1:0] r_opSel;
    logic [3:0] r_keyRound;

    state_t     w_nextState;
    logic [3:0] w_nextRound;
    logic [7:0] w_nextPhase;
    logic       w_nextDir;
    logic       w_peEn, w_loadPsum, w_shiftInEn, w_encDec, w_keyReq, w_busy, w_outValid;
    logic [1:0] w_opSel;
    logic [3:0] w_keyRound;

    // Outputs are decoded from the next state so each register lines up with its state's cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextRound = r_round;
        w_nextPhase = r_phase;
        w_nextDir   = r_dir;
        case (r_state)
            S_IDLE: if (start) begin
                w_nextState = S_LOAD;
                w_nextDir   = enc_dec_in;
                w_nextRound = enc_dec_in ? 4'd0 : LAST_ROUND;
                w_nextPhase = 8'd0;
            end
            S_LOAD: w_nextState = S_KWAIT;
            S_SUB: if (r_phase == SUB_LAST) begin
                w_nextPhase = 8'd0;
                w_nextState = r_dir ? S_SHIFT : S_KWAIT;
            end else begin
                w_nextPhase = r_phase + 8'd1;
            end
            S_SHIFT: if (r_phase == SHIFT_LAST) begin
                w_nextPhase = 8'd0;
                if (!r_dir)                   w_nextState = S_SUB;
                else if (r_round == LAST_ROUND) w_nextState = S_KWAIT;
                else                          w_nextState = S_MIX;
            end else begin
                w_nextPhase = r_phase + 8'd1;
            end
            S_MIX: if (r_dir) begin
                w_nextState = S_KWAIT;
            end else begin
                w_nextState = S_SHIFT;
                w_nextRound = r_round - 4'd1;
            end
            S_KWAIT: if (key_vld) w_nextState = S_ADDK;
            S_ADDK: if (r_dir) begin
                if (r_round == LAST_ROUND) begin
                    w_nextState = S_OUT;
                end else begin
                    w_nextState = S_SUB;
                    w_nextRound = r_round + 4'd1;
                end
            end else begin
                if (r_round == 4'd0) begin
                    w_nextState = S_OUT;
                end else if (r_round == LAST_ROUND) begin
                    w_nextState = S_SHIFT;
                    w_nextRound = r_round - 4'd1;
                end else begin
                    w_nextState = S_MIX;
                end
            end
            S_OUT: if (out_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase

        w_peEn      = (w_nextState == S_LOAD) || (w_nextState == S_SUB) || (w_nextState == S_SHIFT)
                   || (w_nextState == S_MIX) || (w_nextState == S_ADDK);
        w_opSel     = (w_nextState == S_SUB)  ? 2'b01 :
                      (w_nextState == S_MIX)  ? 2'b10 :
                      (w_nextState == S_ADDK) ? 2'b11 : 2'b00;
        w_loadPsum  = (w_nextState == S_LOAD);
        w_shiftInEn = (w_nextState == S_SHIFT);
        w_keyReq    = (w_nextState == S_KWAIT);
        w_keyRound  = ((w_nextState == S_KWAIT) || (w_nextState == S_ADDK)) ? w_nextRound : 4'd0;
        w_busy      = (w_nextState != S_IDLE);
        w_outValid  = (w_nextState == S_OUT);
        w_encDec    = (w_nextState != S_IDLE) ? w_nextDir : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_round     <= 4'd0;
            r_phase     <= 8'd0;
            r_dir       <= 1'b0;
            r_peEn      <= 1'b0;
            r_opSel     <= 2'b00;
            r_loadPsum  <= 1'b0;
            r_shiftInEn <= 1'b0;
            r_encDec    <= 1'b0;
            r_keyReq    <= 1'b0;
            r_keyRound  <= 4'd0;
            r_busy      <= 1'b0;
            r_outValid  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_round     <= w_nextRound;
            r_phase     <= w_nextPhase;
            r_dir       <= w_nextDir;
            r_peEn      <= w_peEn;
            r_opSel     <= w_opSel;
            r_loadPsum  <= w_loadPsum;
            r_shiftInEn <= w_shiftInEn;
            r_encDec    <= w_encDec;
            r_keyReq    <= w_keyReq;
            r_keyRound  <= w_keyRound;
            r_busy      <= w_busy;
            r_outValid  <= w_outValid;
        end
    end

    assign pe_en       = r_peEn;
    assign op_sel      = r_opSel;
    assign load_psum   = r_loadPsum;
    assign shift_in_en = r_shiftInEn;
    assign enc_dec     = r_encDec;
    assign key_req     = r_keyReq;
    assign key_round   = r_keyRound;
    assign busy        = r_busy;
    assign out_valid   = r_outValid;

`ifdef SEQ_PERF_CNT_EN
    logic [7:0] r_cycleCnt;

    // Counts every processing cycle (LOAD through last ADDK), saturating, frozen in OUT/IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycleCnt <= 8'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cycleCnt <= 8'd0;
        end else if ((r_state != S_IDLE) && (r_state != S_OUT) && (r_cycleCnt != 8'hFF)) begin
            r_cycleCnt <= r_cycleCnt + 8'd1;
        end
    end

    assign cycle_cnt = r_cycleCnt;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: vector table, random key delays, corner sequences.
// Build with SEQ_PERF_CNT_EN defined to also check cycle_cnt.
module tb_aes_round_sequencer;

    localparam int SHIFT_CYC = 3;
    localparam int SUB_LAT   = 1;

    logic       clk = 1'b0;
    logic       rst, start, enc_dec_in, key_vld, out_ready;
    logic       pe_en, load_psum, shift_in_en, enc_dec, key_req, busy, out_valid;
    logic [1:0] op_sel;
    logic [3:0] key_round;
`ifdef SEQ_PERF_CNT_EN
    logic [7:0] cycle_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc;
    int keyDelays[11];
    int keyIdx, waitCnt;
    logic [12:0] expQ[$];

    typedef struct {
        logic dir;
        int   delay;
        int   readyHold;
        int   expLat;
    } vec_t;
    vec_t vecs[6];

    aes_round_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .enc_dec_in(enc_dec_in), .key_vld(key_vld),
        .out_ready(out_ready), .pe_en(pe_en), .op_sel(op_sel), .load_psum(load_psum),
        .shift_in_en(shift_in_en), .enc_dec(enc_dec), .key_req(key_req), .key_round(key_round),
        .busy(busy),
`ifdef SEQ_PERF_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic bz, input logic pe, input logic [1:0] op,
                                       input logic ld, input logic sh, input logic kr,
                                       input logic [3:0] kround, input logic ov, input logic ed);
        return {bz, pe, op, ld, sh, kr, kround, ov, ed};
    endfunction

    function automatic logic [12:0] obsWord();
        return {busy, pe_en, op_sel, load_psum, shift_in_en, key_req, key_round, out_valid, enc_dec};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Advance to the next sampling point; answer key requests after the programmed delay.
    task automatic tick();
        int idx;
        @(negedge clk);
        cyc++;
        idx = (keyIdx > 10) ? 10 : keyIdx;
        if (key_req === 1'b1) begin
            if (waitCnt >= keyDelays[idx]) begin
                key_vld = 1'b1;
                waitCnt = 0;
                keyIdx++;
            end else begin
                key_vld = 1'b0;
                waitCnt++;
            end
        end else begin
            key_vld = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pushOp(input logic [1:0] op, input logic ld, input logic sh, input int n, input logic dir);
        for (int j = 0; j < n; j++) expQ.push_back(mk(1, 1, op, ld, sh, 0, 4'd0, 0, dir));
    endtask

    task automatic pushKey(input int r, inout int k, input logic dir);
        for (int j = 0; j <= keyDelays[k]; j++) expQ.push_back(mk(1, 0, 2'b00, 0, 0, 1, 4'(r), 0, dir));
        expQ.push_back(mk(1, 1, 2'b11, 0, 0, 0, 4'(r), 0, dir));
        k++;
    endtask

    // Expected per-cycle control trace, written straight from the AES round order.
    task automatic buildModel(input logic dir);
        int k = 0;
        expQ.delete();
        pushOp(2'b00, 1, 0, 1, dir);
        if (dir) begin
            pushKey(0, k, dir);
            for (int r = 1; r <= 9; r++) begin
                pushOp(2'b01, 0, 0, SUB_LAT, dir);
                pushOp(2'b00, 0, 1, SHIFT_CYC, dir);
                pushOp(2'b10, 0, 0, 1, dir);
                pushKey(r, k, dir);
            end
            pushOp(2'b01, 0, 0, SUB_LAT, dir);
            pushOp(2'b00, 0, 1, SHIFT_CYC, dir);
            pushKey(10, k, dir);
        end else begin
            pushKey(10, k, dir);
            for (int r = 9; r >= 1; r--) begin
                pushOp(2'b00, 0, 1, SHIFT_CYC, dir);
                pushOp(2'b01, 0, 0, SUB_LAT, dir);
                pushKey(r, k, dir);
                pushOp(2'b10, 0, 0, 1, dir);
            end
            pushOp(2'b00, 0, 1, SHIFT_CYC, dir);
            pushOp(2'b01, 0, 0, SUB_LAT, dir);
            pushKey(0, k, dir);
        end
    endtask

    task automatic applyStimulus(input logic dir, input int readyHold, input bit holdStart,
                                 input bit preStarted, input int abortIdx, input int expLat);
        int lat;
        logic [12:0] oword;
        keyIdx = 0;
        waitCnt = 0;
        cyc = 0;
        buildModel(dir);
        enc_dec_in = dir;
        if (!preStarted) start = 1'b1;
        tick();
        if (!holdStart) begin
            start = 1'b0;
            enc_dec_in = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) tick();
            out_ready = 1'($urandom_range(0, 1));
            checkOutput("ctrl", 32'(obsWord()), 32'(expQ[i]));
            if (i == abortIdx) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                out_ready = 1'b0;
                checkOutput("abortIdle", 32'(obsWord()), 32'd0);
                return;
            end
        end
        out_ready = 1'b0;
        lat = -1;
        for (int w = 0; w < 400; w++) begin
            tick();
            if (out_valid === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        if (lat < 0) return;
        oword = mk(1, 0, 2'b00, 0, 0, 0, 4'd0, 1, dir);
        checkOutput("outWord", 32'(obsWord()), 32'(oword));
`ifdef SEQ_PERF_CNT_EN
        checkOutput("cycleCnt", 32'(cycle_cnt), 32'((expLat - 1) > 255 ? 255 : (expLat - 1)));
`endif
        for (int h = 0; h < readyHold; h++) begin
            out_ready = 1'b0;
            if (!holdStart) start = 1'($urandom_range(0, 1));
            tick();
            checkOutput("outHold", 32'(obsWord()), 32'(oword));
        end
        out_ready = 1'b1;
        if (!holdStart) start = 1'b0;
        tick();
        checkOutput("idleAfterOut", 32'(obsWord()), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("cycleCntIdle", 32'(cycle_cnt), 32'((expLat - 1) > 255 ? 255 : (expLat - 1)));
`endif
        if (!holdStart) out_ready = 1'b0;
    endtask

    initial begin
        int sum, abortIdx, mixSeen;
        logic rdir;
        rst = 1'b1;
        start = 1'b0;
        enc_dec_in = 1'b0;
        key_vld = 1'b0;
        out_ready = 1'b0;
        cyc = 0;
        keyIdx = 0;
        waitCnt = 0;
        for (int k = 0; k < 11; k++) keyDelays[k] = 0;
        repeat (3) @(negedge clk);
        checkOutput("resetIdle", 32'(obsWord()), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("resetCnt", 32'(cycle_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick();
        tick();
        checkOutput("idleHold", 32'(obsWord()), 32'd0);

        vecs[0] = '{dir: 1'b1, delay: 0, readyHold: 0,  expLat: 73};
        vecs[1] = '{dir: 1'b0, delay: 0, readyHold: 0,  expLat: 73};
        vecs[2] = '{dir: 1'b1, delay: 2, readyHold: 0,  expLat: 95};
        vecs[3] = '{dir: 1'b0, delay: 2, readyHold: 3,  expLat: 95};
        vecs[4] = '{dir: 1'b1, delay: 1, readyHold: 20, expLat: 84};
        vecs[5] = '{dir: 1'b0, delay: 3, readyHold: 1,  expLat: 106};
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 11; k++) keyDelays[k] = vecs[v].delay;
            applyStimulus(vecs[v].dir, vecs[v].readyHold, 0, 0, -1, vecs[v].expLat);
        end

        for (int n = 0; n < 4; n++) begin
            sum = 0;
            for (int k = 0; k < 11; k++) begin
                keyDelays[k] = int'($urandom_range(0, 3));
                sum += keyDelays[k];
            end
            rdir = 1'($urandom_range(0, 1));
            applyStimulus(rdir, int'($urandom_range(0, 4)), 0, 0, -1, 73 + sum);
        end

        // Abort in the round-5 MixColumns cycle, then a fresh decrypt must run in full.
        for (int k = 0; k < 11; k++) keyDelays[k] = 0;
        buildModel(1'b1);
        abortIdx = -1;
        mixSeen = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (expQ[i][10:9] == 2'b10) begin
                mixSeen++;
                if (mixSeen == 5 && abortIdx < 0) abortIdx = i;
            end
        end
        applyStimulus(1'b1, 0, 0, 0, abortIdx, 73);
        tick();
        checkOutput("abortStaysIdle", 32'(obsWord()), 32'd0);
        applyStimulus(1'b0, 2, 0, 0, -1, 73);

        // start held high: each IDLE cycle launches the next block immediately.
        out_ready = 1'b1;
        applyStimulus(1'b1, 0, 1, 0, -1, 73);
        applyStimulus(1'b1, 0, 1, 1, -1, 73);
        applyStimulus(1'b1, 0, 0, 1, -1, 73);
        tick();
        checkOutput("finalIdle", 32'(obsWord()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
